cam_writer: RTL
===============

CAM_WRITER -- requirements
Module: cam_writer

Interface
REQ-001 SHALL have parameter PIX_PER_LINE, default 640, active pixels (href-high cycles) per line.
REQ-002 SHALL have parameter NUM_LINES, default 480, active lines per frame.
REQ-003 SHALL have parameter HBLANK, default 144, href-low cycles after each line's active pixels.
REQ-004 SHALL have parameters VSYNC_LINES, VBP_LINES and VFP_LINES, defaults 3, 17 and 10, line counts of the vsync, back-porch and front-porch phases.
REQ-005 SHALL have port pclk, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port in_data, input, 8, raw pixel byte from upstream.
REQ-008 SHALL have port in_valid, input, 1, in_data valid.
REQ-009 SHALL have port in_ready, output, 1, byte consumed this cycle when high with in_valid.
REQ-010 SHALL have ports start, input, 1, pulse to begin frames, and stop, input, 1, pulse to end after the current frame.
REQ-011 SHALL have ports vsync, href and dout, outputs, 1/1/8, DVP camera-side bus, all registered.
REQ-012 SHALL have ports busy, output, 1, not IDLE; underflow, output, 1, sticky; frame_cnt, output, 16, completed frames.

Function
REQ-013 SHALL have states IDLE, VSYNC, VBP, ACTIVE and VFP.
REQ-014 SHALL time each line as LINE_LEN = PIX_PER_LINE + HBLANK cycles, with an 11-bit h counter from 0 to LINE_LEN-1 and an 11-bit line counter per phase.
REQ-015 SHALL stay in IDLE until start; when start is sampled high in IDLE, the VSYNC state, busy=1 and vsync=1 SHALL appear on the next cycle.
REQ-016 SHALL in VSYNC drive vsync=1, href=0 for VSYNC_LINES*LINE_LEN cycles, then go to VBP.
REQ-017 SHALL in VBP drive vsync=0, href=0 for VBP_LINES*LINE_LEN cycles, then go to ACTIVE.
REQ-018 SHALL in ACTIVE, for each of NUM_LINES lines, drive href=1 for the first PIX_PER_LINE cycles and href=0 for the next HBLANK cycles, with vsync=0.
REQ-019 SHALL never drive href=1 and vsync=1 in the same cycle.
REQ-020 SHALL in VFP drive both low for VFP_LINES*LINE_LEN cycles; at its last cycle it SHALL increment frame_cnt (16-bit wrap), then go to VSYNC, or to IDLE if a stop is pending.
REQ-021 SHALL drive in_ready=1 exactly in the cycle before each href=1 output cycle; dout in that href cycle SHALL equal the in_data sampled when in_ready&&in_valid.
REQ-022 SHALL handle in_ready=1 with in_valid=0 by driving dout=8'h00 in the following href cycle, setting underflow, and keeping the timing unchanged (no stall).
REQ-023 SHALL hold dout at 8'h00 whenever href=0.
REQ-024 SHALL latch stop when not IDLE into stop_pending, clear it on entry to IDLE, and ignore stop in IDLE.
REQ-025 SHALL ignore start when not IDLE.
REQ-026 SHALL clear underflow only by reset.
REQ-027 SHALL treat all parameters as >=1 and PIX_PER_LINE+HBLANK <= 2047; other values are unsupported.

Reset
REQ-028 SHALL, while rst_n=0 (asserted asynchronously at any time, including mid-frame), force state IDLE, vsync=0, href=0, dout=8'h00, in_ready=0, busy=0, underflow=0, frame_cnt=0 and stop_pending=0.
REQ-029 SHALL, after rst_n is released, stay IDLE until a new start.

Structure
REQ-030 SHALL take state encodings and the default timing constants from the shared header.
REQ-031 SHALL put the h counter, line counter and end-of-line/end-of-phase strobes in one sub-module, cam_writer_timing; cam_writer holds the FSM, handshake and output registers.

Verification (PIX_PER_LINE=4, NUM_LINES=2, HBLANK=2, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1; LINE_LEN=6, frame=30 cycles)
REQ-032 SHALL cover single frame: start pulse, in_valid held 1 with bytes 0x10..0x17, stop pulse during frame -> vsync high 6 cycles, 6 idle cycles, two lines of href high 4 cycles / low 2 cycles with dout 0x10..0x13 then 0x14..0x17, 6 low cycles, frame_cnt=1, busy=0 after 30 cycles.
REQ-033 SHALL cover continuous run: start, no stop -> back-to-back frames with period exactly 30 cycles, frame_cnt=3 after 90 cycles.
REQ-034 SHALL cover underflow: in_valid=0 at the in_ready cycle of the 3rd pixel -> that pixel's dout=0x00, underflow=1 and stays 1, href timing unchanged.
REQ-035 SHALL cover stop and start: stop pulse in VBP of frame 2 -> frame 2 completes, IDLE, frame_cnt=2; start pulse mid-frame -> no effect.
REQ-036 SHALL cover reset mid-ACTIVE: rst_n low during href=1 -> all outputs at reset values immediately, no activity until next start.
REQ-037 SHALL cover protocol check: a receiver model with vsync 3-cycle filtering and href&&!vsync gating reports 4 pixels/line and 2 lines/frame.

Source files
------------

// File: rtl/cam_writer_pkg.sv
// Shared definitions for the DVP camera-side frame writer: state encoding,
// default video timing and counter widths.
package cam_writer_pkg;

  localparam int DEF_PIX_PER_LINE = 640;
  localparam int DEF_NUM_LINES    = 480;
  localparam int DEF_HBLANK       = 144;
  localparam int DEF_VSYNC_LINES  = 3;
  localparam int DEF_VBP_LINES    = 17;
  localparam int DEF_VFP_LINES    = 10;

  localparam int CNT_W = 11;
  localparam int PIX_W = 8;
  localparam int FCNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } cam_state_t;

  // Phase that follows a completed phase; the front porch loops back to vsync
  // unless a stop has been requested.
  function automatic cam_state_t next_phase(input cam_state_t s, input logic stop_req);
    case (s)
      ST_VSYNC:  return ST_VBP;
      ST_VBP:    return ST_ACTIVE;
      ST_ACTIVE: return ST_VFP;
      ST_VFP:    return stop_req ? ST_IDLE : ST_VSYNC;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cam_writer_if.sv
// Pixel stream in (in_data/in_valid/in_ready) and DVP bus out (vsync/href/dout).
// The writer is the master; the upstream source / camera receiver is the slave.
interface cam_writer_if;
  import cam_writer_pkg::*;

  logic [PIX_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             vsync;
  logic             href;
  logic [PIX_W-1:0] dout;

  modport master (input in_data, in_valid, output in_ready, vsync, href, dout);
  modport slave  (output in_data, in_valid, input in_ready, vsync, href, dout);

endinterface

// File: rtl/cam_writer_timing.sv
// Horizontal pixel counter and per-phase line counter with end-of-line and
// end-of-phase strobes. Counters sit at zero while not running so the first
// cycle after leaving IDLE is position (line 0, h 0).
module cam_writer_timing
  import cam_writer_pkg::*;
#(
  parameter int LINE_LEN = DEF_PIX_PER_LINE + DEF_HBLANK
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_phase_lines,
  output logic [CNT_W-1:0] o_h,
  output logic             o_eol,
  output logic             o_eop
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(LINE_LEN - 1);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_line;

  assign o_h   = r_h;
  assign o_eol = i_run && (r_h == H_LAST);
  assign o_eop = o_eol && (r_line == (i_phase_lines - CNT_W'(1)));

  // Advance h every cycle, lines at end of line, restart both at end of phase.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h    <= '0;
      r_line <= '0;
    end else if (!i_run) begin
      r_h    <= '0;
      r_line <= '0;
    end else if (o_eol) begin
      r_h    <= '0;
      r_line <= o_eop ? '0 : r_line + CNT_W'(1);
    end else begin
      r_h <= r_h + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cam_writer.sv
// DVP camera-side frame writer: generates vsync/href timing for back-to-back
// frames and streams upstream bytes onto dout while href is high.
module cam_writer
  import cam_writer_pkg::*;
#(
  parameter int PIX_PER_LINE = DEF_PIX_PER_LINE,
  parameter int NUM_LINES    = DEF_NUM_LINES,
  parameter int HBLANK       = DEF_HBLANK,
  parameter int VSYNC_LINES  = DEF_VSYNC_LINES,
  parameter int VBP_LINES    = DEF_VBP_LINES,
  parameter int VFP_LINES    = DEF_VFP_LINES
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  cam_writer_if.master      bus,
  output logic              busy,
  output logic              underflow,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [CNT_W-1:0] PIX_N = CNT_W'(PIX_PER_LINE);

  cam_state_t        r_state;
  logic              r_vsync;
  logic              r_href;
  logic [PIX_W-1:0]  r_dout;
  logic              r_underflow;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_stop_pending;

  logic [CNT_W-1:0]  w_h;
  logic              w_eol;
  logic              w_eop;
  logic [CNT_W-1:0]  w_phase_lines;
  cam_state_t        w_nstate;
  logic [CNT_W-1:0]  w_h_nxt;
  logic              w_href_nxt;
  logic              w_stop;

  cam_writer_timing #(
    .LINE_LEN(PIX_PER_LINE + HBLANK)
  ) u_timing (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .i_run        (r_state != ST_IDLE),
    .i_phase_lines(w_phase_lines),
    .o_h          (w_h),
    .o_eol        (w_eol),
    .o_eop        (w_eop)
  );

  // Line count of the phase currently being timed.
  always_comb begin
    w_phase_lines = CNT_W'(1);
    case (r_state)
      ST_VSYNC:  w_phase_lines = CNT_W'(VSYNC_LINES);
      ST_VBP:    w_phase_lines = CNT_W'(VBP_LINES);
      ST_ACTIVE: w_phase_lines = CNT_W'(NUM_LINES);
      ST_VFP:    w_phase_lines = CNT_W'(VFP_LINES);
      default:   w_phase_lines = CNT_W'(1);
    endcase
  end

  // Look one cycle ahead so the registered bus lines up with the state;
  // href in the next cycle is exactly when a byte must be taken now.
  always_comb begin
    w_stop   = r_stop_pending | stop;
    w_nstate = r_state;
    if (r_state == ST_IDLE) begin
      if (start) w_nstate = ST_VSYNC;
    end else if (w_eop) begin
      w_nstate = next_phase(r_state, w_stop);
    end
    w_h_nxt    = ((r_state == ST_IDLE) || w_eol) ? '0 : w_h + CNT_W'(1);
    w_href_nxt = (w_nstate == ST_ACTIVE) && (w_h_nxt < PIX_N);
  end

  assign bus.in_ready = w_href_nxt;
  assign bus.vsync    = r_vsync;
  assign bus.href     = r_href;
  assign bus.dout     = r_dout;
  assign busy         = (r_state != ST_IDLE);
  assign underflow    = r_underflow;
  assign frame_cnt    = r_frame_cnt;

  // Frame FSM with registered bus outputs, sticky underflow and frame counter.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_vsync        <= 1'b0;
      r_href         <= 1'b0;
      r_dout         <= '0;
      r_underflow    <= 1'b0;
      r_frame_cnt    <= '0;
      r_stop_pending <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_vsync <= (w_nstate == ST_VSYNC);
      r_href  <= w_href_nxt;
      // A missing byte still produces its href cycle, just with zero data.
      r_dout  <= (w_href_nxt && bus.in_valid) ? bus.in_data : '0;
      if (w_href_nxt && !bus.in_valid) r_underflow <= 1'b1;
      if ((r_state == ST_VFP) && w_eop) r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      if (w_nstate == ST_IDLE)
        r_stop_pending <= 1'b0;
      else if (stop && (r_state != ST_IDLE))
        r_stop_pending <= 1'b1;
    end
  end

endmodule
